// File: rtl/coffee_disp_pkg.sv
// Shared types and default sizing for the coffee machine credit display path.
// Latency: none (declarations only).
// Backpressure: none.
package coffee_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DIGITS = 3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values 5..9 get +3 so the next shift carries into the next digit.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
    import coffee_disp_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    // 4-bit add; inputs never exceed 9 during a valid conversion, so no carry is lost
    assign corrected = (digit >= 4'd5) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/credit_to_bcd.sv
// Binary credit value to packed BCD with leading-zero blanking enables, iterative double-dabble.
// Latency: done pulses WIDTH+1 edges after the edge that accepts start.
// Backpressure: start is ignored while busy (including the done cycle); no queuing.
module credit_to_bcd
    import coffee_disp_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t                state;
    logic [WIDTH-1:0]      bin_q;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   corr;
    logic [CW-1:0]         cnt;
    logic [DIGITS-1:0]     en_next;
    logic                  any_hi;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (scratch[4*g +: 4]),
            .corrected (corr[4*g +: 4])
        );
    end

    // A digit is lit if it or any more significant digit is nonzero; ones always lit.
    always_comb begin
        any_hi  = 1'b0;
        en_next = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            any_hi     = any_hi | (scratch[4*i +: 4] != 4'd0);
            en_next[i] = any_hi;
        end
        en_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            digit_en <= DIGITS'(1);
            scratch  <= '0;
            bin_q    <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cnt counts completed shifts; reaching WIDTH means scratch holds the final result
                    if (cnt == CW'(WIDTH)) begin
                        bcd      <= scratch;
                        digit_en <= en_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        {scratch, bin_q} <= {corr, bin_q} << 1;
                        cnt              <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
